// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its IF/ID register.
package fetch_stage_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // addi x0, x0, 0 -- canonical bubble placed in IF/ID on a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: PC, instruction word and valid bit with hold and flush.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned PC_W = 9,
  parameter logic [31:0] NOP  = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold,
  input  logic            flush,
  input  logic [PC_W-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [PC_W-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic            valid_out
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  // Flush beats hold; otherwise load unless held.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = pc_in;
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (!hold) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  // Register update with synchronous reset to an empty bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALTED FSM, redirect bookkeeping,
// and the IF/ID register feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned PC_W = 9,
  parameter logic [31:0] NOP  = NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Halt,
  input  logic            Stall,
  output logic [PC_W-1:0] InstrAddr,
  input  logic [31:0]     InstrData,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            Halted,
  output logic            Misalign,
  output logic [15:0]     RedirectCnt
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            ifid_hold, ifid_flush;

  // Upper target bits beyond the PC width are don't-care.
  logic unused_brpc;
  assign unused_brpc = ^BrPC;

  // Next-state logic: redirect beats stall; HALTED freezes everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    cnt_d      = cnt_q;
    ifid_hold  = 1'b1;
    ifid_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (PcSel) begin
          pc_d       = {BrPC[PC_W-1:2], 2'b00};
          ifid_flush = 1'b1;
          ifid_hold  = 1'b0;
          if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
          if (BrPC[1:0] != 2'b00) misalign_d = 1'b1;
          if (Halt) state_d = HALTED;
        end else if (!Stall) begin
          pc_d      = pc_q + PC_W'(4);
          ifid_hold = 1'b0;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = RUN;
    endcase
  end

  // FSM, PC and redirect counters in one registered block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      pc_q       <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign InstrAddr   = pc_q;
  assign Halted      = (state_q == HALTED);
  assign Misalign    = misalign_q;
  assign RedirectCnt = cnt_q;

  if_id_reg #(
    .PC_W(PC_W),
    .NOP (NOP)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .hold     (ifid_hold),
    .flush    (ifid_flush),
    .pc_in    (pc_q),
    .instr_in (InstrData),
    .pc_out   (IfId_PC),
    .instr_out(IfId_Instr),
    .valid_out(IfId_Valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stimulus
// against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned PC_W  = 9;
  localparam int unsigned PC_MOD = 512;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk;
  logic            reset;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            Halt;
  logic            Stall;
  logic [PC_W-1:0] InstrAddr;
  logic [31:0]     InstrData;
  logic [PC_W-1:0] IfId_PC;
  logic [31:0]     IfId_Instr;
  logic            IfId_Valid;
  logic            Halted;
  logic            Misalign;
  logic [15:0]     RedirectCnt;

  logic [31:0] mem [128];
  assign InstrData = mem[InstrAddr[8:2]];

  fetch_stage #(
    .PC_W(PC_W),
    .NOP (NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PcSel      (PcSel),
    .BrPC       (BrPC),
    .Halt       (Halt),
    .Stall      (Stall),
    .InstrAddr  (InstrAddr),
    .InstrData  (InstrData),
    .IfId_PC    (IfId_PC),
    .IfId_Instr (IfId_Instr),
    .IfId_Valid (IfId_Valid),
    .Halted     (Halted),
    .Misalign   (Misalign),
    .RedirectCnt(RedirectCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_pc, m_ifpc, m_cnt;
  logic [31:0] m_instr;
  bit          m_valid, m_halted, m_mis;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ifpc = 0; m_instr = NOP; m_valid = 0;
    m_halted = 0; m_mis = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit rst, input bit sel, input logic [31:0] tgt,
                            input bit hlt, input bit stl);
    if (rst) begin
      model_reset();
    end else if (m_halted) begin
      // frozen
    end else if (sel) begin
      m_ifpc  = m_pc;
      m_instr = NOP;
      m_valid = 0;
      m_pc    = ((tgt % PC_MOD) / 4) * 4;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (tgt % 4 != 0) m_mis = 1;
      if (hlt) m_halted = 1;
    end else if (!stl) begin
      m_ifpc  = m_pc;
      m_instr = mem[m_pc / 4];
      m_valid = 1;
      m_pc    = (m_pc + 4) % PC_MOD;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".addr"},  32'(InstrAddr),   m_pc);
    check_eq({tag, ".ifpc"},  32'(IfId_PC),     m_ifpc);
    check_eq({tag, ".instr"}, IfId_Instr,       m_instr);
    check_eq({tag, ".valid"}, 32'(IfId_Valid),  32'(m_valid));
    check_eq({tag, ".halt"},  32'(Halted),      32'(m_halted));
    check_eq({tag, ".mis"},   32'(Misalign),    32'(m_mis));
    check_eq({tag, ".cnt"},   32'(RedirectCnt), m_cnt);
  endtask

  // One clock: drive at negedge, check fetch address, clock, then check state.
  task automatic step(input string tag, input bit rst, input bit sel,
                      input logic [31:0] tgt, input bit hlt, input bit stl);
    @(negedge clk);
    reset = rst; PcSel = sel; BrPC = tgt; Halt = hlt; Stall = stl;
    #1;
    check_eq({tag, ".pre_addr"}, 32'(InstrAddr), m_pc);
    model_step(rst, sel, tgt, hlt, stl);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  int unsigned cnt_before;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    reset = 1'b1; PcSel = 1'b0; BrPC = '0; Halt = 1'b0; Stall = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    step("reset", 1, 0, 32'h0, 0, 0);
    check_eq("reset.instr_nop", IfId_Instr, NOP);

    // Sequential fetch after reset release
    step("seq0", 0, 0, 32'h0, 0, 0);
    check_eq("seq0.ifinstr_mem", IfId_Instr, mem[0]);
    step("seq1", 0, 0, 32'h0, 0, 0);
    check_eq("seq1.addr8", 32'(InstrAddr), 32'h8);
    check_eq("seq1.ifpc4", 32'(IfId_PC), 32'h4);

    // Redirect to 0x40 from 0x08
    step("redir40", 0, 1, 32'h40, 0, 0);
    check_eq("redir40.pc", 32'(InstrAddr), 32'h40);
    check_eq("redir40.cnt", 32'(RedirectCnt), 32'd1);
    check_eq("redir40.valid", 32'(IfId_Valid), 32'd0);

    // Stall at 0x10 for two cycles, then redirect while stalled
    step("go10", 0, 1, 32'h10, 0, 0);
    step("stall0", 0, 0, 32'h0, 0, 1);
    step("stall1", 0, 0, 32'h0, 0, 1);
    check_eq("stall1.pc_hold", 32'(InstrAddr), 32'h10);
    step("stall_redir", 0, 1, 32'h20, 0, 1);
    check_eq("stall_redir.pc", 32'(InstrAddr), 32'h20);
    check_eq("stall_redir.valid", 32'(IfId_Valid), 32'd0);

    // Wrap from top of PC space, then misaligned redirect with high bits set
    step("go1fc", 0, 1, 32'h1FC, 0, 0);
    step("wrap", 0, 0, 32'h0, 0, 0);
    check_eq("wrap.pc0", 32'(InstrAddr), 32'h0);
    step("mis", 0, 1, 32'h0000_0206, 0, 0);
    check_eq("mis.pc4", 32'(InstrAddr), 32'h4);
    check_eq("mis.flag", 32'(Misalign), 32'd1);

    // Halt on redirect to 0x30, then ignored activity
    cnt_before = 32'(RedirectCnt);
    step("halt", 0, 1, 32'h30, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step("halted", 0, bit'(i % 2 == 0), $urandom, bit'($urandom_range(0, 1)), bit'(i % 2 == 1));
      check_eq("halted.pc", 32'(InstrAddr), 32'h30);
      check_eq("halted.flag", 32'(Halted), 32'd1);
      check_eq("halted.valid", 32'(IfId_Valid), 32'd0);
      check_eq("halted.cnt", 32'(RedirectCnt), cnt_before + 1);
    end
    step("unhalt_reset", 1, 1, 32'h44, 1, 1);
    check_eq("unhalt.pc", 32'(InstrAddr), 32'h0);
    check_eq("unhalt.halt", 32'(Halted), 32'd0);
    check_eq("unhalt.mis", 32'(Misalign), 32'd0);
    check_eq("unhalt.cnt", 32'(RedirectCnt), 32'd0);

    // Halt without PcSel does nothing
    step("halt_nosel", 0, 0, 32'h80, 1, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bit rst, sel, hlt, stl;
      rst = ($urandom_range(0, 39) == 0);
      sel = ($urandom_range(0, 4) == 0);
      hlt = ($urandom_range(0, 5) == 0);
      stl = ($urandom_range(0, 2) == 0);
      step("rand", rst, sel, $urandom, hlt, stl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
